// File: rtl/reg_scoreboard_if.sv
// Issue / write-back / status bundle between decode and the register scoreboard.
// The master side is decode plus MEM/WB. The slave side is the scoreboard.
interface reg_scoreboard_if;
  logic        i_stall;
  logic        i_issue_valid;
  logic [3:0]  i_issue_rd;
  logic        i_issue_rd_en;
  logic [3:0]  i_src_a;
  logic [3:0]  i_src_b;
  logic        i_src_a_en;
  logic        i_src_b_en;
  logic [3:0]  i_wb_addr;
  logic        i_wb_en;
  logic        o_hazard;
  logic [15:0] o_busy_r;
  logic        o_err_r;

  modport master (
    output i_stall, i_issue_valid, i_issue_rd, i_issue_rd_en,
           i_src_a, i_src_b, i_src_a_en, i_src_b_en, i_wb_addr, i_wb_en,
    input  o_hazard, o_busy_r, o_err_r
  );

  modport slave (
    input  i_stall, i_issue_valid, i_issue_rd, i_issue_rd_en,
           i_src_a, i_src_b, i_src_a_en, i_src_b_en, i_wb_addr, i_wb_en,
    output o_hazard, o_busy_r, o_err_r
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks up to 3 in-flight writes for each of 16 registers and flags RAW and saturation hazards.
// Optional feature macro SCOREBOARD_WB_BYPASS_EN forwards a same-cycle final write-back and clears that source hazard.
module reg_scoreboard (
  input  logic             clk,
  input  logic             rst,
  reg_scoreboard_if.slave  sb
);

  logic [1:0]  cnt [16];
  logic [15:0] inc_vec;
  logic [15:0] dec_vec;
  logic [15:0] busy;
  logic        src_a_haz;
  logic        src_b_haz;
  logic        rd_sat;
  logic        hazard;
  logic        issue_fire;
  logic        wb_hit;
  logic        wb_orphan;
  logic        err_q;

  always_comb begin
    src_a_haz = sb.i_src_a_en && (cnt[sb.i_src_a] != 2'd0);
    src_b_haz = sb.i_src_b_en && (cnt[sb.i_src_b] != 2'd0);
`ifdef SCOREBOARD_WB_BYPASS_EN
    // The last outstanding write is landing now, so its value can be forwarded.
    if (sb.i_wb_en && (sb.i_wb_addr == sb.i_src_a) && (cnt[sb.i_src_a] == 2'd1))
      src_a_haz = 1'b0;
    if (sb.i_wb_en && (sb.i_wb_addr == sb.i_src_b) && (cnt[sb.i_src_b] == 2'd1))
      src_b_haz = 1'b0;
`endif
    rd_sat     = sb.i_issue_rd_en && (cnt[sb.i_issue_rd] == 2'd3);
    hazard     = sb.i_issue_valid && (src_a_haz || src_b_haz || rd_sat);
    issue_fire = sb.i_issue_valid && sb.i_issue_rd_en && !hazard && !sb.i_stall;
    wb_hit     = sb.i_wb_en && (cnt[sb.i_wb_addr] != 2'd0);
    wb_orphan  = sb.i_wb_en && (cnt[sb.i_wb_addr] == 2'd0);
  end

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (issue_fire) inc_vec[sb.i_issue_rd] = 1'b1;
    if (wb_hit)     dec_vec[sb.i_wb_addr]  = 1'b1;
  end

  // A simultaneous issue and retire on the same register cancel each other out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < 16; r++) cnt[r] <= 2'd0;
      err_q <= 1'b0;
    end else begin
      for (int r = 0; r < 16; r++) begin
        case ({inc_vec[r], dec_vec[r]})
          2'b10:   cnt[r] <= cnt[r] + 2'd1;
          2'b01:   cnt[r] <= cnt[r] - 2'd1;
          default: cnt[r] <= cnt[r];
        endcase
      end
      if (wb_orphan) err_q <= 1'b1;
    end
  end

  always_comb begin
    busy = '0;
    for (int r = 0; r < 16; r++) busy[r] = (cnt[r] != 2'd0);
  end

  assign sb.o_hazard = hazard;
  assign sb.o_busy_r = busy;
  assign sb.o_err_r  = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard. The expected values are worked out by hand for each scenario.
// These scenarios cover reset, RAW hazards, saturation, issue/retire collision, stall, orphan write-back and mid-run reset.
module tb_reg_scoreboard;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  reg_scoreboard_if sb_if ();

  reg_scoreboard dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb_if)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    sb_if.i_stall       = 1'b0;
    sb_if.i_issue_valid = 1'b0;
    sb_if.i_issue_rd    = 4'd0;
    sb_if.i_issue_rd_en = 1'b0;
    sb_if.i_src_a       = 4'd0;
    sb_if.i_src_b       = 4'd0;
    sb_if.i_src_a_en    = 1'b0;
    sb_if.i_src_b_en    = 1'b0;
    sb_if.i_wb_addr     = 4'd0;
    sb_if.i_wb_en       = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic issue(input logic [3:0] rd);
    sb_if.i_issue_valid = 1'b1;
    sb_if.i_issue_rd    = rd;
    sb_if.i_issue_rd_en = 1'b1;
  endtask

  task automatic wb(input logic [3:0] addr);
    sb_if.i_wb_en   = 1'b1;
    sb_if.i_wb_addr = addr;
  endtask

  initial begin
    idle_inputs();
    #1 rst = 1'b0;
    #2;
    check_val("rst_busy_async", 32'(sb_if.o_busy_r), 32'h0);
    check_val("rst_err_async", 32'(sb_if.o_err_r), 32'h0);
    tick();
    rst = 1'b1;
    tick();
    check_val("idle_busy", 32'(sb_if.o_busy_r), 32'h0);
    check_val("idle_hazard", 32'(sb_if.o_hazard), 32'h0);
    check_val("idle_err", 32'(sb_if.o_err_r), 32'h0);

    // RAW hazard on r3, then retirement
    do_reset();
    issue(4'd3);
    #1 check_val("raw_first_issue_hz", 32'(sb_if.o_hazard), 32'h0);
    tick();
    check_val("raw_busy_r3", 32'(sb_if.o_busy_r), 32'h0008);
    issue(4'd4);
    sb_if.i_src_a    = 4'd3;
    sb_if.i_src_a_en = 1'b1;
    idle_inputs_keep: begin end
    #1 check_val("raw_hazard_a", 32'(sb_if.o_hazard), 32'h1);
    tick();
    check_val("raw_held_busy", 32'(sb_if.o_busy_r), 32'h0008);
    wb(4'd3);
`ifdef SCOREBOARD_WB_BYPASS_EN
    #1 check_val("raw_wb_cycle_hz", 32'(sb_if.o_hazard), 32'h0);
    tick();
    check_val("raw_after_wb_busy", 32'(sb_if.o_busy_r), 32'h0010);
`else
    #1 check_val("raw_wb_cycle_hz", 32'(sb_if.o_hazard), 32'h1);
    tick();
    check_val("raw_after_wb_busy", 32'(sb_if.o_busy_r), 32'h0000);
`endif
    sb_if.i_wb_en = 1'b0;
    #1 check_val("raw_post_wb_hz", 32'(sb_if.o_hazard), 32'h0);
    sb_if.i_issue_valid = 1'b0;
    #1 check_val("no_valid_no_hz", 32'(sb_if.o_hazard), 32'h0);

    // src_b hazard
    do_reset();
    issue(4'd9);
    tick();
    sb_if.i_issue_rd_en = 1'b0;
    sb_if.i_src_b       = 4'd9;
    sb_if.i_src_b_en    = 1'b1;
    #1 check_val("srcb_hazard", 32'(sb_if.o_hazard), 32'h1);
    sb_if.i_src_b_en = 1'b0;
    #1 check_val("srcb_unused_hz", 32'(sb_if.o_hazard), 32'h0);

    // Saturation on r13 (first issue lands on the first edge after reset)
    do_reset();
    issue(4'd13);
    tick();
    check_val("sat_first_edge_busy", 32'(sb_if.o_busy_r), 32'h2000);
    tick();
    tick();
    check_val("sat_hazard", 32'(sb_if.o_hazard), 32'h1);
    tick();
    check_val("sat_busy_held", 32'(sb_if.o_busy_r), 32'h2000);
    sb_if.i_issue_valid = 1'b0;
    wb(4'd13);
    tick();
    tick();
    check_val("sat_two_wb_busy", 32'(sb_if.o_busy_r), 32'h2000);
    tick();
    sb_if.i_wb_en = 1'b0;
    check_val("sat_drained_busy", 32'(sb_if.o_busy_r), 32'h0000);
    check_val("sat_no_err", 32'(sb_if.o_err_r), 32'h0);

    // Issue and retire collide on r5; stall blocks issue but not write-back
    do_reset();
    issue(4'd5);
    tick();
    wb(4'd5);
    tick();
    check_val("collide_busy", 32'(sb_if.o_busy_r), 32'h0020);
    sb_if.i_issue_valid = 1'b0;
    tick();
    sb_if.i_wb_en = 1'b0;
    check_val("collide_cnt_was_1", 32'(sb_if.o_busy_r), 32'h0000);
    check_val("collide_no_err", 32'(sb_if.o_err_r), 32'h0);
    issue(4'd5);
    tick();
    issue(4'd6);
    sb_if.i_stall = 1'b1;
    wb(4'd5);
    tick();
    check_val("stall_busy", 32'(sb_if.o_busy_r), 32'h0000);
    idle_inputs();

    // Orphan write-back, sticky error, mid-run reset
    do_reset();
    issue(4'd2);
    wb(4'd7);
    #1 check_val("orphan_err_before", 32'(sb_if.o_err_r), 32'h0);
    tick();
    check_val("orphan_err_set", 32'(sb_if.o_err_r), 32'h1);
    check_val("orphan_busy", 32'(sb_if.o_busy_r), 32'h0004);
    idle_inputs();
    tick();
    tick();
    check_val("orphan_err_sticky", 32'(sb_if.o_err_r), 32'h1);
    sb_if.i_issue_valid = 1'b1;
    sb_if.i_src_a       = 4'd2;
    sb_if.i_src_a_en    = 1'b1;
    #1 check_val("pre_rst_hazard", 32'(sb_if.o_hazard), 32'h1);
    #2 rst = 1'b0;
    #1;
    check_val("midrst_busy", 32'(sb_if.o_busy_r), 32'h0);
    check_val("midrst_err", 32'(sb_if.o_err_r), 32'h0);
    check_val("midrst_hazard", 32'(sb_if.o_hazard), 32'h0);
    idle_inputs();
    tick();
    rst = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 SHALL have ports: clk  input  1  sole clock, rising-edge; rst  input  1  asynchronous, active-low reset.
REQ-002 SHALL have: i_stall  input  1  pipeline stall; no issue is recorded while high.
REQ-003 SHALL have: i_issue_valid  input  1  decode stage presents an instruction.
REQ-004 SHALL have: i_issue_rd  input  4  destination register of the issuing instruction; i_issue_rd_en  input  1  the instruction writes a register.
REQ-005 SHALL have: i_src_a, i_src_b  input  4 each  source registers; i_src_a_en, i_src_b_en  input  1 each  source used.
REQ-006 SHALL have: i_wb_addr  input  4  write-back destination; i_wb_en  input  1  write-back occurring this cycle (driven from the MEM/WB control registers).
REQ-007 SHALL have: o_hazard  output  1  combinational, decode must hold the instruction.
REQ-008 SHALL have: o_busy_r  output  16  registered, bit r = register r has at least one write in flight.
REQ-009 SHALL have: o_err_r  output  1  sticky, write-back arrived for a register with nothing pending.

Function
REQ-010 SHALL hold a 2-bit pending counter cnt[r] for each register r in 0..15.
REQ-011 SHALL define issue_fire = i_issue_valid & i_issue_rd_en & ~o_hazard & ~i_stall.
REQ-012 SHALL increment cnt[i_issue_rd] by 1 at the next rising edge when issue_fire is high.
REQ-013 SHALL decrement cnt[i_wb_addr] by 1 at the next edge when i_wb_en is high and cnt[i_wb_addr] != 0.
REQ-014 SHALL leave cnt unchanged when issue_fire and a valid decrement target the same register in the same cycle.
REQ-015 SHALL ignore a write-back to a register with cnt == 0, and set o_err_r at the next edge.
REQ-016 SHALL honour write-back regardless of i_stall and o_hazard.
REQ-017 SHALL raise o_hazard when i_issue_valid is high and any of the following holds: i_src_a_en with cnt[i_src_a] != 0; i_src_b_en with cnt[i_src_b] != 0; i_issue_rd_en with cnt[i_issue_rd] == 3 (saturation).
REQ-018 SHALL keep o_hazard low when i_issue_valid is low.
REQ-019 SHALL drive o_busy_r[r] = (cnt[r] != 0) from registered state, so it reflects the counter value after each edge.
REQ-020 SHALL never wrap a counter: 3 plus issue is prevented by REQ-017, and 0 minus write-back is prevented by REQ-015.
REQ-021 SHALL keep o_err_r at 1 until reset.

Reset
REQ-022 SHALL, while rst is low, asynchronously clear all cnt, o_busy_r = 0 and o_err_r = 0.
REQ-023 SHALL discard in-flight state on reset mid-operation, and accept issue on the first rising edge after rst goes high.

Configuration
REQ-024 SHALL support macro SCOREBOARD_WB_BYPASS_EN.
REQ-025 With SCOREBOARD_WB_BYPASS_EN defined, a source hazard SHALL be suppressed when i_wb_en is high, i_wb_addr equals that source, and its cnt == 1 (same-cycle write-back forwarding).
REQ-026 Without SCOREBOARD_WB_BYPASS_EN, a source hazard SHALL depend on cnt only, so there is one extra stall cycle after write-back.

Verification
REQ-027 Reset then idle -> o_busy_r = 16'h0000, o_hazard = 0, o_err_r = 0.
REQ-028 Issue rd=3, then next cycle issue src_a=3 -> o_hazard = 1 and o_busy_r = 16'h0008; after wb_addr=3 retires, o_hazard drops (bypass on: same cycle; bypass off: next cycle).
REQ-029 Three issues to rd=13 with no write-back, then a fourth -> o_hazard = 1, cnt[13] stays 3, o_busy_r[13] = 1.
REQ-030 Simultaneous issue rd=5 and wb_addr=5 with cnt[5] = 1 -> cnt[5] stays 1; i_stall = 1 during issue -> cnt unchanged.
REQ-031 wb_addr=7 with cnt[7] = 0 -> o_err_r = 1, and it stays 1; assert rst low mid-sequence -> immediate clear of all outputs.
